qam_tx_source: RTL



---
 rtl/qam_tx_source.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/qam_tx_source.sv
// rtl/qam_tx_source.sv - PRBS-driven Gray-coded square M-QAM test source with per-rail upsampling
//
// Ports:
//   clk          system clock (sys_clk)
//   reset        asynchronous, active-high
//   sam_clk_en   one-cycle sample enable
//   hold_mode    0 = zero-stuff, 1 = sample-and-hold between symbols
//   load         reload the LFSR from seed_in (0 selects SEED); wins over an emit
//   seed_in      seed value for load
//   i_out/q_out  signed 1s17 in-phase / quadrature samples
//   sym_strobe   high the cycle after a symbol is emitted
//   sym_bits     raw PRBS bits of the current symbol
//   cycle_mark   pulses with sym_strobe when the symbol came from state == SEED
//   err_inject   (only with QAM_TX_ERR_INJECT_EN) arms a one-shot I-field bit flip
//
// Optional feature macro: QAM_TX_ERR_INJECT_EN
module qam_tx_source #(
  parameter int BITS_PER_SYM = 4,
  parameter int UPSAMPLE     = 4,
  parameter int OUT_WIDTH    = 18,
  parameter int LEVEL_STEP   = 8192,
  parameter logic [21:0] SEED = 22'h3FFFFF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sam_clk_en,
  input  logic                        hold_mode,
  input  logic                        load,
  input  logic [21:0]                 seed_in,
`ifdef QAM_TX_ERR_INJECT_EN
  input  logic                        err_inject,
`endif
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        sym_strobe,
  output logic [BITS_PER_SYM-1:0]     sym_bits,
  output logic                        cycle_mark
);

  localparam int H  = BITS_PER_SYM / 2;
  localparam int L  = 1 << H;
  localparam int WW = OUT_WIDTH + 4;
  localparam int CW = $clog2(UPSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(UPSAMPLE - 1);

  localparam logic signed [WW-1:0] OFFS    = WW'(L - 1);
  localparam logic signed [WW-1:0] STEP_W  = WW'(LEVEL_STEP);
  localparam logic signed [WW-1:0] SAT_MAX = WW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

  if (BITS_PER_SYM < 2 || BITS_PER_SYM > 8 || (BITS_PER_SYM % 2) != 0) begin : g_bad_bps
    $error("qam_tx_source: BITS_PER_SYM must be even and in 2..8");
  end
  if (UPSAMPLE < 2 || UPSAMPLE > 16) begin : g_bad_ups
    $error("qam_tx_source: UPSAMPLE must be in 2..16");
  end
  if (SEED == 22'h0) begin : g_bad_seed
    $error("qam_tx_source: SEED must be non-zero");
  end

  // Gray field -> index k -> level (2k-(L-1))*LEVEL_STEP, saturated to OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] map_level(input logic [H-1:0] g);
    logic [H-1:0]           k;
    logic signed [WW-1:0]   lvl;
    k[H-1] = g[H-1];
    for (int i = H - 2; i >= 0; i--) begin
      k[i] = k[i+1] ^ g[i];
    end
    lvl = ($signed(WW'({k, 1'b0})) - OFFS) * STEP_W;
    if (lvl > SAT_MAX)      map_level = SAT_MAX[OUT_WIDTH-1:0];
    else if (lvl < SAT_MIN) map_level = SAT_MIN[OUT_WIDTH-1:0];
    else                    map_level = lvl[OUT_WIDTH-1:0];
  endfunction

  logic [21:0]   lfsr;
  logic [CW-1:0] phase;
  logic          emit;
  logic [H-1:0]  i_field;
  logic [H-1:0]  q_field;

  assign emit = sam_clk_en && !load && (phase == '0);

`ifdef QAM_TX_ERR_INJECT_EN
  localparam logic [H-1:0] I_FLIP = H'(1) << (H - 1);
  logic armed;

  // The flip lands on the I-field MSB, turning e.g. Gray 11 into 01.
  assign i_field = lfsr[BITS_PER_SYM-1:H] ^ (armed ? I_FLIP : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (emit) begin
      // A pulse coinciding with the consuming emit re-arms only if nothing was pending.
      armed <= err_inject && !armed;
    end else if (err_inject) begin
      armed <= 1'b1;
    end
  end
`else
  assign i_field = lfsr[BITS_PER_SYM-1:H];
`endif

  assign q_field = lfsr[H-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr       <= SEED;
      phase      <= '0;
      i_out      <= '0;
      q_out      <= '0;
      sym_strobe <= 1'b0;
      sym_bits   <= '0;
      cycle_mark <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      cycle_mark <= 1'b0;
      if (load) begin
        lfsr  <= (seed_in == 22'h0) ? SEED : seed_in;
        phase <= '0;
        i_out <= '0;
        q_out <= '0;
      end else if (sam_clk_en) begin
        phase <= (phase == LAST) ? '0 : phase + CW'(1);
        if (emit) begin
          lfsr       <= {lfsr[20:0], lfsr[21] ^ lfsr[20]};
          sym_bits   <= lfsr[BITS_PER_SYM-1:0];
          i_out      <= map_level(i_field);
          q_out      <= map_level(q_field);
          sym_strobe <= 1'b1;
          cycle_mark <= (lfsr == SEED);
        end else if (!hold_mode) begin
          i_out <= '0;
          q_out <= '0;
        end
      end
    end
  end

endmodule
